exec_element_issuer: RTL

// - Initiator side of the exec-element handshake: accepts one decoded instruction, launches an exec element, waits for completion, returns its result.
// - Sits between issue/decode and one exec element (FPU ALU, etc.); one instance per element; one operation in flight.
// - Element protocol: elem_reset=1 clears elem_completed; elem_reset=0 lets the element run; elem_completed rises and stays high with elem_out valid.

---
 rtl/felis_exec_pkg.sv | 24 ++
 rtl/exec_timeout_counter.sv | 32 +++
 rtl/exec_element_issuer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/felis_exec_pkg.sv
// rtl/felis_exec_pkg.sv - shared types and widths for the exec-element issuer
package felis_exec_pkg;

    localparam int INST_NUM_W = 6;
    localparam int REG_IDX_W  = 5;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } issuer_state_t;

    typedef struct packed {
        logic [INST_NUM_W-1:0] inst_num;
        logic [WORD_W-1:0]     rs;
        logic [WORD_W-1:0]     rt;
        logic [WORD_W-1:0]     fs;
        logic [WORD_W-1:0]     ft;
        logic [REG_IDX_W-1:0]  dest;
        logic                  dest_fpr;
    } issue_req_t;

endpackage

// File: rtl/exec_timeout_counter.sv
// rtl/exec_timeout_counter.sv - saturating RUN-cycle counter with expiry flag
module exec_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at LAST instead of wrapping; the issuer leaves RUN there anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/exec_element_issuer.sv
// rtl/exec_element_issuer.sv - launches one exec element per request and returns its result
module exec_element_issuer
    import felis_exec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [INST_NUM_W-1:0] issue_inst_num,
    input  logic [WORD_W-1:0]     issue_rs,
    input  logic [WORD_W-1:0]     issue_rt,
    input  logic [WORD_W-1:0]     issue_fs,
    input  logic [WORD_W-1:0]     issue_ft,
    input  logic [REG_IDX_W-1:0]  issue_dest,
    input  logic                  issue_dest_fpr,
    output logic                  elem_reset,
    output logic [INST_NUM_W-1:0] elem_inst_num,
    output logic [WORD_W-1:0]     elem_rs,
    output logic [WORD_W-1:0]     elem_rt,
    output logic [WORD_W-1:0]     elem_fs,
    output logic [WORD_W-1:0]     elem_ft,
    input  logic                  elem_completed,
    input  logic [WORD_W-1:0]     elem_out,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_IDX_W-1:0]  wb_dest,
    output logic                  wb_dest_fpr,
    output logic [WORD_W-1:0]     wb_data,
    output logic                  err_timeout
);

    issuer_state_t     state_q, state_d;
    issue_req_t        req_q, req_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic              issue_ready_q, issue_ready_d;
    logic              wb_valid_q, wb_valid_d;
    logic              err_timeout_q, err_timeout_d;
    logic              accept;
    logic              expired;

    assign accept = issue_valid & issue_ready_q;

    exec_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .clear  (reset | accept),
        .enable (state_q == RUN),
        .expired(expired)
    );

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        wb_data_d     = wb_data_q;
        err_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    req_d.inst_num = issue_inst_num;
                    req_d.rs       = issue_rs;
                    req_d.rt       = issue_rt;
                    req_d.fs       = issue_fs;
                    req_d.ft       = issue_ft;
                    req_d.dest     = issue_dest;
                    req_d.dest_fpr = issue_dest_fpr;
                    state_d        = RUN;
                end
            end
            RUN: begin
                // Completion is checked first so a late result beats the abort.
                if (elem_completed) begin
                    wb_data_d = elem_out;
                    state_d   = WB;
                end else if (expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            WB: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        issue_ready_d = (state_d == IDLE);
        wb_valid_d    = (state_d == WB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_q         <= '0;
            wb_data_q     <= '0;
            issue_ready_q <= 1'b1;
            wb_valid_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            wb_data_q     <= wb_data_d;
            issue_ready_q <= issue_ready_d;
            wb_valid_q    <= wb_valid_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Outside RUN the element is held in reset, which also clears any stale completion.
    assign elem_reset    = reset | (state_q != RUN);
    assign elem_inst_num = req_q.inst_num;
    assign elem_rs       = req_q.rs;
    assign elem_rt       = req_q.rt;
    assign elem_fs       = req_q.fs;
    assign elem_ft       = req_q.ft;

    assign issue_ready = issue_ready_q;
    assign wb_valid    = wb_valid_q;
    assign wb_dest     = req_q.dest;
    assign wb_dest_fpr = req_q.dest_fpr;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_timeout_q;

endmodule
